// File: rtl/vx_ahb_mem_subordinate_if.sv
// AHB-Lite bus bundle between one manager and the memory subordinate.
interface vx_ahb_mem_subordinate_if #(
   parameter int AHB_ADDR_WIDTH = 32,
   parameter int AHB_DATA_WIDTH = 32
);
   logic                      HSEL;
   logic [AHB_ADDR_WIDTH-1:0] HADDR;
   logic [1:0]                HTRANS;
   logic [2:0]                HSIZE;
   logic                      HWRITE;
   logic [AHB_DATA_WIDTH-1:0] HWDATA;
   logic [AHB_DATA_WIDTH-1:0] HRDATA;
   logic                      HREADY;
   logic                      HRESP;

   modport master (
      output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA,
      input  HRDATA, HREADY, HRESP
   );

   modport slave (
      input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA,
      output HRDATA, HREADY, HRESP
   );
endinterface

// File: rtl/vx_ahb_mem_subordinate.sv
// AHB-Lite word-addressed memory subordinate with fixed wait states and a
// two-cycle ERROR response; 32-bit NONSEQ/SEQ transfers only.
//
// state | meaning
// IDLE  | no data phase pending, HREADY=1
// WAIT  | legal transfer stalled, HREADY=0, wait counter running
// DONE  | last data-phase cycle, read data out / write commits at edge
// ERR1  | first ERROR cycle, HREADY=0 HRESP=1
// ERR2  | second ERROR cycle, HREADY=1 HRESP=1
module vx_ahb_mem_subordinate #(
   parameter int                        AHB_DATA_WIDTH = 32,
   parameter int                        AHB_ADDR_WIDTH = 32,
   parameter int                        DEPTH_WORDS    = 1024,
   parameter logic [AHB_ADDR_WIDTH-1:0] BASE_ADDR      = 32'h0000_0000,
   parameter int                        WAIT_STATES    = 0
) (
   input logic                     clk,
   input logic                     reset,
   vx_ahb_mem_subordinate_if.slave ahb
);

   localparam int                      IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [AHB_ADDR_WIDTH:0] SPAN      = (AHB_ADDR_WIDTH+1)'(DEPTH_WORDS) << 2;
   localparam logic [AHB_ADDR_WIDTH:0] LO_ADDR   = {1'b0, BASE_ADDR};
   localparam logic [AHB_ADDR_WIDTH:0] HI_ADDR   = LO_ADDR + SPAN;
   localparam logic [3:0]              WAIT_LAST = 4'(WAIT_STATES);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DONE,
      ST_ERR1,
      ST_ERR2
   } state_t;

   state_t                    state_q, state_d;
   logic [3:0]                wait_cnt_q, wait_cnt_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic                      write_q, write_d;
   logic [AHB_DATA_WIDTH-1:0] hrdata_q, hrdata_d;

   logic [AHB_DATA_WIDTH-1:0] mem [DEPTH_WORDS];
   logic [AHB_DATA_WIDTH-1:0] rd_word;
   logic [AHB_ADDR_WIDTH-1:0] offset;
   logic [AHB_ADDR_WIDTH:0]   haddr_x;
   logic                      in_range;
   logic                      legal;
   logic                      accept;
   logic                      hready;
   logic                      hresp;
   logic                      mem_we;
   logic                      unused_bits;

   // Extra top bit keeps the range compare exact when the window ends at 2**AW.
   assign haddr_x  = {1'b0, ahb.HADDR};
   assign in_range = (haddr_x >= LO_ADDR) && (haddr_x < HI_ADDR);
   assign offset   = ahb.HADDR - BASE_ADDR;
   assign legal    = in_range && (ahb.HSIZE == 3'b010) && (ahb.HADDR[1:0] == 2'b00);
   assign accept   = hready && ahb.HSEL && ahb.HTRANS[1];
   assign rd_word  = mem[idx_q];

   assign unused_bits = ^{ahb.HTRANS[0], offset};

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      idx_d      = idx_q;
      write_d    = write_q;
      hrdata_d   = hrdata_q;
      hready     = 1'b1;
      hresp      = 1'b0;
      mem_we     = 1'b0;

      case (state_q)
         ST_IDLE: begin
         end
         ST_WAIT: begin
            hready     = 1'b0;
            wait_cnt_d = wait_cnt_q + 4'd1;
            if (wait_cnt_q + 4'd1 == WAIT_LAST) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            if (write_q) begin
               mem_we = 1'b1;
            end else begin
               hrdata_d = rd_word;
            end
         end
         ST_ERR1: begin
            hready  = 1'b0;
            hresp   = 1'b1;
            state_d = ST_ERR2;
         end
         ST_ERR2: begin
            hresp   = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A new address phase may overlap the final cycle of the previous one.
      if (accept) begin
         idx_d      = offset[IDX_W+1:2];
         write_d    = ahb.HWRITE;
         wait_cnt_d = 4'd0;
         if (!legal) begin
            state_d = ST_ERR1;
         end else if (WAIT_STATES == 0) begin
            state_d = ST_DONE;
         end else begin
            state_d = ST_WAIT;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         wait_cnt_q <= 4'd0;
         idx_q      <= '0;
         write_q    <= 1'b0;
         hrdata_q   <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         idx_q      <= idx_d;
         write_q    <= write_d;
         hrdata_q   <= hrdata_d;
      end
   end

   // Storage is deliberately left out of reset so it behaves as plain RAM.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[idx_q] <= ahb.HWDATA;
      end
   end

   assign ahb.HREADY = hready;
   assign ahb.HRESP  = hresp;
   assign ahb.HRDATA = ((state_q == ST_DONE) && !write_q) ? rd_word : hrdata_q;

endmodule

// File: tb/tb_vx_ahb_mem_subordinate.sv
// Directed bench: three subordinates (0, 3 and 5 wait states) share one
// pipelined stimulus bus; HSEL is steered to the instance under test.
module tb_vx_ahb_mem_subordinate;
   localparam logic [31:0] BASE  = 32'h1000_0000;
   localparam int          DEPTH = 1024;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int sel   = 0;

   logic        hsel;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic [2:0]  hsize;
   logic        hwrite;
   logic [31:0] hwdata;
   logic        hready_m, hresp_m;
   logic [31:0] hrdata_m;

   vx_ahb_mem_subordinate_if bus0 ();
   vx_ahb_mem_subordinate_if bus3 ();
   vx_ahb_mem_subordinate_if bus5 ();

   assign bus0.HSEL = hsel && (sel == 0);
   assign bus3.HSEL = hsel && (sel == 1);
   assign bus5.HSEL = hsel && (sel == 2);
   assign bus0.HADDR = haddr;   assign bus3.HADDR = haddr;   assign bus5.HADDR = haddr;
   assign bus0.HTRANS = htrans; assign bus3.HTRANS = htrans; assign bus5.HTRANS = htrans;
   assign bus0.HSIZE = hsize;   assign bus3.HSIZE = hsize;   assign bus5.HSIZE = hsize;
   assign bus0.HWRITE = hwrite; assign bus3.HWRITE = hwrite; assign bus5.HWRITE = hwrite;
   assign bus0.HWDATA = hwdata; assign bus3.HWDATA = hwdata; assign bus5.HWDATA = hwdata;

   assign hready_m = (sel == 0) ? bus0.HREADY : (sel == 1) ? bus3.HREADY : bus5.HREADY;
   assign hresp_m  = (sel == 0) ? bus0.HRESP  : (sel == 1) ? bus3.HRESP  : bus5.HRESP;
   assign hrdata_m = (sel == 0) ? bus0.HRDATA : (sel == 1) ? bus3.HRDATA : bus5.HRDATA;

   vx_ahb_mem_subordinate #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(0))
      dut0 (.clk(clk), .reset(reset), .ahb(bus0));
   vx_ahb_mem_subordinate #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(3))
      dut3 (.clk(clk), .reset(reset), .ahb(bus3));
   vx_ahb_mem_subordinate #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(5))
      dut5 (.clk(clk), .reset(reset), .ahb(bus5));

   // Transfer list and per-transfer results for the pipelined driver.
   int          seq_n = 0;
   logic        seq_w  [40];
   logic [31:0] seq_a  [40];
   logic [31:0] seq_d  [40];
   logic [2:0]  seq_sz [40];
   logic [31:0] res_rd [40];
   logic        res_resp [40];
   logic        res_lo_resp [40];
   int          res_wait [40];
   int          seq_cycles;

   task automatic idle_bus();
      hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
      haddr = 32'h0; hsize = 3'b010; hwdata = 32'h0;
   endtask

   task automatic add(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] sz);
      seq_w[seq_n] = w; seq_a[seq_n] = a; seq_d[seq_n] = d; seq_sz[seq_n] = sz;
      seq_n++;
   endtask

   task automatic drive_slot(input int k, input int dp);
      if (k < seq_n) begin
         hsel = 1'b1; htrans = 2'b10; hwrite = seq_w[k];
         haddr = seq_a[k]; hsize = seq_sz[k];
      end else begin
         hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = 32'h0; hsize = 3'b010;
      end
      hwdata = (dp >= 0) ? seq_d[dp] : 32'h0;
   endtask

   task automatic run_seq();
      int k, dp, cyc;
      k = 0; dp = -1; cyc = 0;
      for (int i = 0; i < seq_n; i++) begin
         res_rd[i] = 32'h0; res_resp[i] = 1'b0; res_lo_resp[i] = 1'b0; res_wait[i] = 0;
      end
      drive_slot(k, dp);
      forever begin
         @(negedge clk);
         cyc++;
         if (hready_m) begin
            if (dp >= 0) begin
               res_rd[dp] = hrdata_m;
               res_resp[dp] = hresp_m;
            end
            if (k < seq_n) begin
               dp = k; k++;
            end else begin
               dp = -1;
            end
         end else if (dp >= 0) begin
            res_wait[dp]++;
            res_lo_resp[dp] = res_lo_resp[dp] | hresp_m;
         end
         @(posedge clk); #1;
         if (dp < 0 && k >= seq_n) break;
         if (cyc > 2000) begin
            total++; bad++;
            $display("FAIL seq_timeout cycles=%0d limit=2000", cyc);
            break;
         end
         drive_slot(k, dp);
      end
      idle_bus();
      seq_cycles = cyc;
      seq_n = 0;
   endtask

   task automatic test_reset();
      idle_bus();
      #2 reset = 1'b0;
      #1;
      total++;
      if ({bus0.HREADY, bus0.HRESP, bus0.HRDATA} !== {1'b1, 1'b0, 32'h0}) begin
         bad++; $display("FAIL reset_dut0 got=%b/%b/%h exp=1/0/00000000", bus0.HREADY, bus0.HRESP, bus0.HRDATA);
      end
      total++;
      if ({bus3.HREADY, bus3.HRESP, bus3.HRDATA} !== {1'b1, 1'b0, 32'h0}) begin
         bad++; $display("FAIL reset_dut3 got=%b/%b/%h exp=1/0/00000000", bus3.HREADY, bus3.HRESP, bus3.HRDATA);
      end
      total++;
      if ({bus5.HREADY, bus5.HRESP, bus5.HRDATA} !== {1'b1, 1'b0, 32'h0}) begin
         bad++; $display("FAIL reset_dut5 got=%b/%b/%h exp=1/0/00000000", bus5.HREADY, bus5.HRESP, bus5.HRDATA);
      end
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_wr_rd_b2b();
      sel = 0;
      add(1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 3'b010);
      add(1'b0, BASE + 32'h10, 32'h0, 3'b010);
      run_seq();
      total++;
      if (res_rd[1] !== 32'hDEAD_BEEF) begin
         bad++; $display("FAIL wr_rd_data got=%h exp=deadbeef", res_rd[1]);
      end
      total++;
      if ({res_resp[1], res_lo_resp[1], res_wait[1]} !== {1'b0, 1'b0, 32'd0}) begin
         bad++; $display("FAIL wr_rd_resp got resp=%b waits=%0d exp resp=0 waits=0", res_resp[1], res_wait[1]);
      end
   endtask

   task automatic test_wait_states();
      sel = 1;
      add(1'b1, BASE, 32'h1234_5678, 3'b010);
      run_seq();
      total++;
      if (res_wait[0] !== 3) begin
         bad++; $display("FAIL ws3_write_waits got=%0d exp=3", res_wait[0]);
      end
      add(1'b0, BASE, 32'h0, 3'b010);
      run_seq();
      total++;
      if (res_wait[0] !== 3) begin
         bad++; $display("FAIL ws3_read_waits got=%0d exp=3", res_wait[0]);
      end
      total++;
      if ({res_resp[0], res_rd[0]} !== {1'b0, 32'h1234_5678}) begin
         bad++; $display("FAIL ws3_read_data got=%b/%h exp=0/12345678", res_resp[0], res_rd[0]);
      end
   endtask

   task automatic test_back_to_back();
      int wsum;
      sel = 0;
      for (int i = 0; i < 16; i++) add(1'b1, BASE + 32'h40 + 32'(4 * i), 32'(i), 3'b010);
      for (int i = 0; i < 16; i++) add(1'b0, BASE + 32'h40 + 32'(4 * i), 32'h0, 3'b010);
      run_seq();
      for (int i = 0; i < 16; i++) begin
         total++;
         if (res_rd[16 + i] !== 32'(i)) begin
            bad++; $display("FAIL b2b_read_%0d got=%h exp=%h", i, res_rd[16 + i], 32'(i));
         end
      end
      wsum = 0;
      for (int i = 0; i < 32; i++) wsum += res_wait[i] + int'(res_resp[i]);
      total++;
      if (wsum !== 0) begin
         bad++; $display("FAIL b2b_waits_resp got=%0d exp=0", wsum);
      end
      total++;
      if (seq_cycles !== 33) begin
         bad++; $display("FAIL b2b_cycles got=%0d exp=33", seq_cycles);
      end
   endtask

   task automatic test_errors();
      sel = 0;
      add(1'b1, BASE,            32'h1111_0000, 3'b010);
      add(1'b1, BASE + 32'h20,   32'h2222_0000, 3'b010);
      add(1'b1, BASE + 32'h3FC,  32'h3333_0000, 3'b010);
      add(1'b1, BASE + 32'(DEPTH * 4), 32'hBAD0_BAD0, 3'b010);
      add(1'b1, BASE + 32'h2,    32'hBAD0_BAD1, 3'b010);
      add(1'b1, BASE + 32'h20,   32'hBAD0_BAD2, 3'b011);
      add(1'b1, BASE - 32'h4,    32'hBAD0_BAD3, 3'b010);
      add(1'b0, BASE,            32'h0, 3'b010);
      add(1'b0, BASE + 32'h20,   32'h0, 3'b010);
      add(1'b0, BASE + 32'h3FC,  32'h0, 3'b010);
      run_seq();
      total++;
      if ({res_resp[2], res_wait[2]} !== {1'b0, 32'd0}) begin
         bad++; $display("FAIL err_last_word_ok got resp=%b waits=%0d exp resp=0 waits=0", res_resp[2], res_wait[2]);
      end
      for (int i = 3; i < 7; i++) begin
         total++;
         if ({res_lo_resp[i], res_resp[i], res_wait[i]} !== {1'b1, 1'b1, 32'd1}) begin
            bad++; $display("FAIL err_resp_%0d got err1=%b err2=%b lowcycles=%0d exp err1=1 err2=1 lowcycles=1",
                            i - 3, res_lo_resp[i], res_resp[i], res_wait[i]);
         end
      end
      total++;
      if (res_rd[7] !== 32'h1111_0000) begin
         bad++; $display("FAIL err_word0 got=%h exp=11110000", res_rd[7]);
      end
      total++;
      if (res_rd[8] !== 32'h2222_0000) begin
         bad++; $display("FAIL err_word8 got=%h exp=22220000", res_rd[8]);
      end
      total++;
      if (res_rd[9] !== 32'h3333_0000) begin
         bad++; $display("FAIL err_lastword got=%h exp=33330000", res_rd[9]);
      end
   endtask

   task automatic test_idle_nosel();
      sel = 0;
      add(1'b1, BASE + 32'h30, 32'h3333_3333, 3'b010);
      run_seq();
      hsel = 1'b1; htrans = 2'b00; hwrite = 1'b1; haddr = BASE + 32'h30;
      hsize = 3'b010; hwdata = 32'hFFFF_FFFF;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         total++;
         if ({hready_m, hresp_m} !== 2'b10) begin
            bad++; $display("FAIL idle_cycle_%0d got ready=%b resp=%b exp ready=1 resp=0", c, hready_m, hresp_m);
         end
         @(posedge clk); #1;
         if (c == 0) htrans = 2'b01;
         if (c == 1) begin hsel = 1'b0; htrans = 2'b10; end
      end
      idle_bus();
      add(1'b0, BASE + 32'h30, 32'h0, 3'b010);
      run_seq();
      total++;
      if (res_rd[0] !== 32'h3333_3333) begin
         bad++; $display("FAIL idle_mem_unchanged got=%h exp=33333333", res_rd[0]);
      end
   endtask

   task automatic test_reset_mid_wait();
      int guard;
      sel = 2;
      add(1'b1, BASE + 32'h50, 32'h0F0F_0F0F, 3'b010);
      add(1'b0, BASE + 32'h50, 32'h0, 3'b010);
      run_seq();
      total++;
      if (res_rd[1] !== 32'h0F0F_0F0F) begin
         bad++; $display("FAIL ws5_preload got=%h exp=0f0f0f0f", res_rd[1]);
      end
      hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = BASE + 32'h50; hsize = 3'b010;
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (!hready_m && guard < 50);
      @(posedge clk); #1;
      idle_bus();
      hwdata = 32'hA5A5_A5A5;
      @(posedge clk); #1;
      total++;
      if (hready_m !== 1'b0) begin
         bad++; $display("FAIL ws5_in_wait got ready=%b exp=0", hready_m);
      end
      reset = 1'b0;
      #1;
      total++;
      if ({bus5.HREADY, bus5.HRESP, bus5.HRDATA} !== {1'b1, 1'b0, 32'h0}) begin
         bad++; $display("FAIL ws5_reset_outputs got=%b/%b/%h exp=1/0/00000000", bus5.HREADY, bus5.HRESP, bus5.HRDATA);
      end
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      hwdata = 32'h0;
      add(1'b0, BASE + 32'h50, 32'h0, 3'b010);
      run_seq();
      total++;
      if (res_rd[0] !== 32'h0F0F_0F0F) begin
         bad++; $display("FAIL ws5_aborted_write got=%h exp=0f0f0f0f", res_rd[0]);
      end
   endtask

   initial begin
      idle_bus();
      test_reset();
      test_wr_rd_b2b();
      test_wait_states();
      test_back_to_back();
      test_errors();
      test_idle_nosel();
      test_reset_mid_wait();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
